// File: rtl/thistle_pkg.sv
// Shared definitions for the thistle machine: default bus widths and the
// program-loader state encoding, used by the loader, the RAM and the CPU
// controller so that all three agree on widths and loader state values.
package thistle_pkg;

  // Default RAM address and data widths for the whole machine.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Program-loader states. The values are fixed so that other blocks
  // (for example a debug readout in the CPU controller) can decode them.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SET_MAR   = 3'd2,
    ST_WRITE     = 3'd3,
    ST_FINISH    = 3'd4
  } ld_state_e;

endpackage : thistle_pkg

// File: rtl/prog_loader.sv
// Program loader: copies a stream of host bytes into RAM at base_addr..base_addr+length-1.
// Latency: 3 cycles per byte (wait, set MAR, write); done pulses in the cycle after the last write.
// Backpressure: byte_ready is high only while waiting for a byte; an offered byte is held off otherwise.
module prog_loader
  import thistle_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              program_mode,
  output logic              pm_mar_wr,
  output logic [ADDR_W-1:0] pm_mar_in,
  output logic              pm_we,
  output logic [DATA_W-1:0] pm_data,
  output logic              busy,
  output logic              done
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [DATA_W-1:0] byte_q;

  // Count still to go once the current write retires. A length of zero
  // means a full address space: 0 - 1 wraps to all-ones, which is nonzero,
  // so the load continues for 2^ADDR_W bytes.
  logic [ADDR_W-1:0] remaining_dec;
  assign remaining_dec = remaining_q - ADDR_W'(1);

  // Loader FSM with address/remaining counters; every output is a register
  // set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      byte_q       <= '0;
      byte_ready   <= 1'b0;
      program_mode <= 1'b0;
      pm_mar_wr    <= 1'b0;
      pm_mar_in    <= '0;
      pm_we        <= 1'b0;
      pm_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      // Abort drops the RAM immediately; a pending write is abandoned and
      // no completion pulse is produced.
      state_q      <= ST_IDLE;
      byte_ready   <= 1'b0;
      program_mode <= 1'b0;
      pm_mar_wr    <= 1'b0;
      pm_we        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An abort coinciding with start cancels the start.
          if (start && !abort) begin
            addr_q       <= base_addr;
            remaining_q  <= length;
            program_mode <= 1'b1;
            busy         <= 1'b1;
            byte_ready   <= 1'b1;
            state_q      <= ST_WAIT_BYTE;
          end
        end
        ST_WAIT_BYTE: begin
          // byte_ready is high throughout this state, so valid alone
          // completes the handshake.
          if (byte_valid) begin
            byte_q     <= byte_in;
            byte_ready <= 1'b0;
            pm_mar_wr  <= 1'b1;
            pm_mar_in  <= addr_q;
            state_q    <= ST_SET_MAR;
          end
        end
        ST_SET_MAR: begin
          pm_mar_wr <= 1'b0;
          pm_we     <= 1'b1;
          pm_data   <= byte_q;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          pm_we       <= 1'b0;
          addr_q      <= addr_q + ADDR_W'(1);
          remaining_q <= remaining_dec;
          if (remaining_dec != '0) begin
            byte_ready <= 1'b1;
            state_q    <= ST_WAIT_BYTE;
          end else begin
            // RAM is handed back in the same cycle that done is reported.
            done         <= 1'b1;
            program_mode <= 1'b0;
            state_q      <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          byte_ready   <= 1'b0;
          program_mode <= 1'b0;
          pm_mar_wr    <= 1'b0;
          pm_we        <= 1'b0;
          busy         <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a byte source, a simple RAM bus model and an
// expected-memory image built from base/length/data, plus handshake and
// strobe invariants checked every cycle.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, byte_valid;
  logic [7:0] base_addr, length, byte_in;
  logic       byte_ready, program_mode, pm_mar_wr, pm_we, busy, done;
  logic [7:0] pm_mar_in, pm_data;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .program_mode(program_mode), .pm_mar_wr(pm_mar_wr), .pm_mar_in(pm_mar_in),
    .pm_we(pm_we), .pm_data(pm_data), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int viol;
  int tot_we;
  logic [7:0] ram [256];
  logic [7:0] exp_ram [256];
  int         wr_cnt [256];
  logic [7:0] mar;
  logic [7:0] tx [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // RAM bus model sampled mid-cycle, plus strobe invariants.
  task automatic ram_watch();
    if (pm_mar_wr && pm_we) viol++;
    if (!program_mode && (pm_mar_wr || pm_we)) viol++;
    if (pm_mar_wr) mar = pm_mar_in;
    if (pm_we) begin
      ram[mar] = pm_data;
      wr_cnt[mar]++;
      tot_we++;
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    int bad = 0;
    tot_we = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ram_watch();
      if (busy || program_mode || byte_ready || done || pm_mar_wr || pm_we) bad++;
    end
    chk({tag, " quiet"}, bad, 0);
  endtask

  // One load. kill_mode: 0 none, 1 abort, 2 rst, applied while the MAR
  // strobe of byte number kill_at is visible. exp_done_k < 0 skips timing.
  task automatic run_load(input string tag, input logic [7:0] base, input int n,
                          input int gap, input bit rnd_gap, input int kill_mode,
                          input int kill_at, input bit junk, input int exp_done_k);
    int  idx, g, mar_seen, done_k, done_cnt, exp_n, bad_d, bad_c;
    bit  take, prev_rdy, prev_take, kill_pend, after_done, fin;
    logic [31:0] r;
    for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
    viol = 0; tot_we = 0;
    idx = 0; g = 0; mar_seen = 0; done_k = -1; done_cnt = 0;
    prev_rdy = 0; prev_take = 0; kill_pend = 0; after_done = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = 8'(n);
    byte_valid = 1'b1; byte_in = tx[0];   // offered early, held off in IDLE
    for (int k = 0; k < 1200 && !fin; k++) begin
      @(negedge clk);
      ram_watch();
      if (k == 0) begin
        chk({tag, " started"}, {program_mode, busy, byte_ready}, 3'b111);
        start = 1'b0;
      end
      if (prev_take && byte_ready) viol++;
      if (prev_rdy && !prev_take && !byte_ready && !kill_pend) viol++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        if (program_mode) viol++;
      end
      if (kill_pend) begin
        chk({tag, " killed"}, {busy, program_mode, byte_ready, pm_mar_wr, pm_we, done}, 6'b0);
        if (kill_mode == 2)
          chk({tag, " rst outs"}, {pm_mar_in, pm_data}, 16'h0);
        abort = 1'b0; rst = 1'b0; fin = 1;
      end else if (after_done) begin
        chk({tag, " after done"}, {busy, program_mode, done}, 3'b000);
        fin = 1;
      end else begin
        if (done) after_done = 1;
        if (pm_mar_wr) begin
          mar_seen++;
          if (kill_mode != 0 && mar_seen == kill_at) begin
            if (kill_mode == 1) abort = 1'b1; else rst = 1'b1;
            kill_pend = 1;
          end
        end
      end
      if (fin) begin
        start = 1'b0; byte_valid = 1'b0;
      end else begin
        if (idx < n && g == 0) begin
          byte_valid = 1'b1; byte_in = tx[idx];
        end else begin
          byte_valid = 1'b0;
          if (g > 0) g--;
        end
        take = byte_valid && byte_ready;
        if (take) begin
          idx++;
          g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
        end
        prev_rdy = byte_ready; prev_take = take;
        if (junk && k > 0) begin
          r = $urandom;
          start = r[0]; base_addr = r[15:8]; length = r[23:16];
        end
      end
    end
    chk({tag, " finished"}, fin, 1);
    exp_n = (kill_mode != 0) ? kill_at - 1 : n;
    for (int i = 0; i < exp_n; i++) exp_ram[8'(int'(base) + i)] = tx[i];
    bad_d = 0; bad_c = 0;
    for (int a = 0; a < 256; a++) begin
      if (ram[a] !== exp_ram[a]) bad_d++;
      if (wr_cnt[a] != (((a - int'(base) + 256) % 256) < exp_n ? 1 : 0)) bad_c++;
    end
    chk({tag, " ram image"}, bad_d, 0);
    chk({tag, " write counts"}, bad_c, 0);
    chk({tag, " total writes"}, tot_we, exp_n);
    chk({tag, " done pulses"}, done_cnt, (kill_mode != 0) ? 0 : 1);
    chk({tag, " invariants"}, viol, 0);
    if (exp_done_k >= 0) chk({tag, " done cycle"}, done_k, exp_done_k);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a] = 8'h00; exp_ram[a] = 8'h00; wr_cnt[a] = 0;
    end
    mar = 8'h00; viol = 0; tot_we = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    base_addr = 8'h00; length = 8'h00; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset outputs",
        {byte_ready, program_mode, pm_mar_wr, pm_we, busy, done, pm_mar_in, pm_data}, 22'h0);
    rst = 1'b0;
    idle_cycles("post reset", 3);

    // Back-to-back bytes: done is high in cycle 3n+1 counted from the start edge.
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC;
    run_load("basic", 8'h10, 3, 0, 0, 0, 0, 0, 9);

    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03;
    run_load("wrap", 8'hFE, 3, 0, 0, 0, 0, 0, 9);

    for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
    run_load("throttle", 8'h40, 4, 5, 0, 0, 0, 0, -1);

    for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
    run_load("abort", 8'h20, 4, 0, 0, 1, 2, 0, -1);
    idle_cycles("after abort", 3);
    for (int i = 0; i < 2; i++) tx[i] = 8'($urandom);
    run_load("after abort load", 8'h30, 2, 0, 0, 0, 0, 0, 6);

    // Abort together with start in IDLE cancels the start.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 8'h77; length = 8'h05;
    @(negedge clk);
    ram_watch();
    chk("abort+start idle", {busy, program_mode, byte_ready}, 3'b000);
    start = 1'b0; abort = 1'b0;
    idle_cycles("abort+start", 2);

    for (int i = 0; i < 5; i++) tx[i] = 8'($urandom);
    run_load("reset midload", 8'h50, 5, 0, 0, 2, 3, 0, -1);
    idle_cycles("after reset", 4);
    for (int i = 0; i < 3; i++) tx[i] = 8'($urandom);
    run_load("after reset load", 8'h58, 3, 1, 0, 0, 0, 0, -1);

    for (int i = 0; i < 256; i++) tx[i] = 8'(i);
    run_load("full 256", 8'h00, 256, 0, 0, 0, 0, 0, 768);

    for (int t = 0; t < 4; t++) begin
      int n;
      logic [7:0] b;
      n = int'($urandom_range(20, 1));
      b = 8'($urandom);
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
      run_load("random", b, n, 3, 1, 0, 0, 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, RAM address width; DATA_W, 8, RAM data width.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a load; sampled in IDLE only.
REQ-005 base_addr  input  ADDR_W  first RAM address to write; sampled with start.
REQ-006 length  input  ADDR_W  byte count to load; 0 encodes 2^ADDR_W (256); sampled with start.
REQ-007 abort  input  1  terminate the load in progress.
REQ-008 byte_in  input  DATA_W  program byte from host/UART side.
REQ-009 byte_valid  input  1  byte_in is valid.
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 program_mode  output  1  drives RAM program_mode; RAM owned by loader while high.
REQ-012 pm_mar_wr  output  1  RAM MAR load strobe, program-mode side.
REQ-013 pm_mar_in  output  ADDR_W  RAM MAR value, program-mode side.
REQ-014 pm_we  output  1  RAM write strobe, program-mode side.
REQ-015 pm_data  output  DATA_W  RAM write data, program-mode side.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 All outputs SHALL be registered; states IDLE, WAIT_BYTE, SET_MAR, WRITE, FINISH.
REQ-019 IDLE: start=1 at an edge -> WAIT_BYTE next cycle; addr<=base_addr, remaining<=length; program_mode, busy rise in that cycle.
REQ-020 WAIT_BYTE: byte_ready=1; transfer occurs when byte_valid & byte_ready at an edge; byte latched; -> SET_MAR.
REQ-021 byte_ready SHALL be 0 in every state other than WAIT_BYTE; byte_valid without ready is held off, never dropped or duplicated.
REQ-022 SET_MAR: pm_mar_wr=1 for exactly one cycle with pm_mar_in=addr; -> WRITE.
REQ-023 WRITE: pm_we=1 for exactly one cycle with pm_data=latched byte; pm_mar_wr=0; on exit addr<=addr+1, remaining<=remaining-1.
REQ-024 After WRITE: remaining (post-decrement) nonzero -> WAIT_BYTE; zero -> FINISH.
REQ-025 Minimum throughput: 3 cycles per byte (WAIT_BYTE, SET_MAR, WRITE) with byte_valid held high.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_W: addr 8'hFF increments to 8'h00, no error.
REQ-027 length=0 SHALL load 256 bytes (remaining decrement wraps 0 -> 8'hFF on first byte).
REQ-028 FINISH: done=1 for one cycle, program_mode=0 in that same cycle; -> IDLE.
REQ-029 pm_mar_wr and pm_we SHALL never be high in the same cycle; both SHALL be 0 whenever program_mode=0.
REQ-030 abort=1 in any non-IDLE state -> IDLE next cycle with program_mode, strobes, byte_ready, busy all 0; done NOT pulsed; a write in progress is not completed.
REQ-031 abort has priority over byte handshake; abort and start together in IDLE -> start ignored.
REQ-032 start while busy SHALL be ignored; base_addr/length changes while busy have no effect.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE; addr, remaining, latched byte to 0; every output 0; takes priority over abort/start.
REQ-034 rst mid-load SHALL release program_mode next cycle; no further RAM strobes until a new start.

Structure
REQ-035 State encoding and ADDR_W/DATA_W defaults SHALL live in shared package thistle_pkg, reused by ram and the CPU controller.
REQ-036 No sub-module; FSM, address counter and remaining counter reside in prog_loader.

Verification
REQ-037 base_addr=8'h10, length=3, bytes AA,BB,CC, byte_valid held high -> RAM[10..12]=AA,BB,CC; done pulses once, 10 cycles after start edge; program_mode low afterwards.
REQ-038 base_addr=8'hFE, length=3, bytes 01,02,03 -> RAM[FE]=01, RAM[FF]=02, RAM[00]=03.
REQ-039 Throttled source: byte_valid low for 5 cycles between bytes -> loader waits in WAIT_BYTE, byte_ready stays high, no extra strobes, each byte written exactly once.
REQ-040 abort asserted in SET_MAR of 2nd byte (length=4) -> only 1st byte written, done never pulses, busy/program_mode 0 next cycle, next start works normally.
REQ-041 rst asserted mid-load then released, then CPU reads via normal oe path -> program_mode=0, RAM bus driven by normal path only; start again loads correctly.
REQ-042 length=0, base 8'h00, incrementing data -> all 256 locations written, done after 769 cycles.
